// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues a request-to-send, then shifts an 8-bit command
// plus odd parity out on device-generated clock falls and checks the ack.
// Optional feature macro: PS2_TX_RETRY_EN (replay a failed frame twice more
// before reporting tx_err).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

`ifdef PS2_TX_RETRY_EN
    localparam logic [1:0] MAX_RETRY = 2'd2;
`else
    localparam logic [1:0] MAX_RETRY = 2'd0;
`endif

    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_FIRST, S_SHIFT, S_ACK, S_WAIT_IDLE, S_ERR
    } state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [31:0]   tmr_q, tmr_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    frame_q, frame_d;
    logic [1:0]    try_q, try_d;

    // Clock debounce: a new level is taken only after FILTER_LEN consecutive
    // samples disagree with the current filtered level.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1))
                filt_d = clk_s2_q;
            else
                fcnt_d = fcnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;
    end

    // Synchronizers and filter state; idle bus level is high so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_in;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Transfer FSM: next state, timers and pad enables.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q + 32'd1;
        idx_d       = idx_q;
        frame_d     = frame_q;
        try_d       = try_q;
        tx_ready    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        busy        = 1'b1;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                tx_ready = 1'b1;
                tmr_d    = '0;
                if (tx_valid) begin
                    frame_d = {~^tx_data, tx_data};
                    try_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            // The REQ cycle is the last cycle of the clock-low window, so the
            // clock is pulled low for exactly INHIBIT_CYCLES cycles in total.
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (tmr_q == 32'(INHIBIT_CYCLES - 2))
                    state_d = S_REQ;
            end
            S_REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                tmr_d       = '0;
                state_d     = S_WAIT_FIRST;
            end
            // Start bit (data low) is held until the device's first fall.
            S_WAIT_FIRST: begin
                ps2_data_oe = 1'b1;
                if (fall) begin
                    idx_d   = '0;
                    tmr_d   = '0;
                    state_d = S_SHIFT;
                end else if (tmr_q == 32'(START_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_SHIFT: begin
                ps2_data_oe = ~frame_q[idx_q];
                if (fall) begin
                    if (idx_q == 4'd8)
                        state_d = S_ACK;
                    else
                        idx_d = idx_q + 1'b1;
                end else if (tmr_q == 32'(XFER_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_ACK: begin
                if (fall)
                    state_d = dat_s2_q ? S_ERR : S_WAIT_IDLE;
                else if (tmr_q == 32'(XFER_TIMEOUT - 1))
                    state_d = S_ERR;
            end
            S_WAIT_IDLE: begin
                if (filt_q && dat_s2_q) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end else if (tmr_q == 32'(XFER_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                tmr_d = '0;
                if (try_q != MAX_RETRY) begin
                    try_d   = try_q + 1'b1;
                    state_d = S_INHIBIT;
                end else begin
                    tx_err  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            try_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            try_q   <= try_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;
    localparam int IC = 100;
    localparam int ST = 3000;
    localparam int XT = 4000;
    localparam int FL = 8;
    localparam int HP = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic dev_clk = 1'b1, dev_dat = 1'b1, glitch = 1'b0;
    logic tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, clk_oe, data_oe, busy, tx_done, tx_err;
    logic ps2_clk_in, ps2_data_in;

    // Open-collector bus: either side can pull a line low.
    assign ps2_clk_in  = ~clk_oe & dev_clk & ~glitch;
    assign ps2_data_in = ~data_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(IC), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT), .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    int vecs = 0;
    int bad  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_err;
        bit          chk_rx;
        logic [10:0] rx;
        int          inh;
        bit          chk_to;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] dev_rx = '0;

    // Line image of a frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    // Monitor: inhibit length, release time, and scoreboard on done/err.
    initial begin
        int run = 0, inh = 0, rel = 0, cyc = 0;
        bit pend = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                run = 0; inh = 0; pend = 0;
            end else begin
                if (pend) begin
                    chk("pulse_width", 32'(tx_done | tx_err), 0);
                    chk("busy_after", 32'(busy), 0);
                    pend = 0;
                end else if (tx_done || tx_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("kind_err", 32'(tx_err), 32'(e.is_err));
                        chk("kind_done", 32'(tx_done), 32'(!e.is_err));
                        chk("busy_at_pulse", 32'(busy), 1);
                        chk("inhibit_phases", 32'(inh), 32'(e.inh));
                        if (e.chk_rx) chk("frame_bits", 32'(dev_rx), 32'(e.rx));
                        if (e.chk_to) chk("start_timeout", 32'(cyc - rel), ST);
                        if (tx_err) chk("oe_at_err", 32'({clk_oe, data_oe}), 0);
                    end
                    inh  = 0;
                    pend = 1;
                end
                if (clk_oe) begin
                    if (run == 0) inh++;
                    run++;
                end else if (run != 0) begin
                    chk("inhibit_len", 32'(run), IC);
                    run = 0;
                    rel = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_oe(input logic lvl, output bit ok);
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            if (clk_oe === lvl) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("wait_clk_oe", 0, 1);
    endtask

    // Device model. mode 0: ack, 1: no ack, 2: silent. abort_at: stop after that fall.
    task automatic dev_xfer(input int mode, input bit glt, input int abort_at);
        bit ok;
        wait_oe(1'b1, ok);
        if (!ok) return;
        wait_oe(1'b0, ok);
        if (!ok || mode == 2) return;
        tick(50);
        dev_rx    = '0;
        dev_rx[0] = ps2_data_in;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10 && mode == 0) dev_dat = 1'b0;
            dev_clk = 1'b0;
            if (k == abort_at) return;
            tick(HP);
            dev_clk = 1'b1;
            if (k <= 9) dev_rx[k+1] = ps2_data_in;
            if (glt && (k == 2 || k == 6)) begin
                tick(12); glitch = 1'b1; tick(3); glitch = 1'b0; tick(HP - 15);
            end else begin
                tick(HP);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_ready(input string nm);
        bit ok = 0;
        for (int i = 0; i < 12000; i++) begin
            if (tx_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    task automatic send(input logic [7:0] d, input int mode, input bit glt);
        exp_t e;
        int   n;
        wait_ready("ready_before");
        e.is_err = (mode != 0);
        e.chk_rx = (mode != 2);
        e.rx     = frame_of(d);
        n        = (mode == 0) ? 1 : ATT;
        e.inh    = n;
        e.chk_to = (mode == 2);
        exp_q.push_back(e);
        tx_valid = 1'b1; tx_data = d;
        tick(1);
        tx_valid = 1'b0; tx_data = 8'($urandom);
        for (int a = 0; a < n; a++) dev_xfer(mode, glt, -1);
        wait_ready("ready_after");
        tick(3);
        chk("drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        tick(3);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_clk_oe", 32'(clk_oe), 0);
        chk("rst_data_oe", 32'(data_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_err", 32'(tx_err), 0);
        rst = 1'b0;
        tick(20);

        send(8'hED, 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        send(8'hF4, 0, 1'b0);
        send(8'hA5, 2, 1'b0);
        send(8'hED, 1, 1'b0);

        // Reset while bit 4 is on the wire: no pulse may follow.
        wait_ready("ready_rst");
        tx_valid = 1'b1; tx_data = 8'hED;
        tick(1);
        tx_valid = 1'b0;
        dev_xfer(0, 1'b0, 4);
        tick(20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_oe", 32'({clk_oe, data_oe}), 0);
        chk("midrst_ready", 32'(tx_ready), 1);
        dev_clk = 1'b1; dev_dat = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);

        send(8'h55, 0, 1'b0);
        send(8'h3C, 0, 1'b1);
        for (int i = 0; i < 6; i++) send(8'($urandom), 0, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
